// File: rtl/port_controller_pkg.sv
// Shared constants for the port controller: port address map and status bit layout.
package port_controller_pkg;

    localparam logic [2:0] PORT_OUT0   = 3'd0;
    localparam logic [2:0] PORT_OUT1   = 3'd1;
    localparam logic [2:0] PORT_OUT2   = 3'd2;
    localparam logic [2:0] PORT_OUT3   = 3'd3;
    localparam logic [2:0] PORT_IN4    = 3'd4;
    localparam logic [2:0] PORT_IN5    = 3'd5;
    localparam logic [2:0] PORT_STATUS = 3'd6;
    localparam logic [2:0] PORT_STREAM = 3'd7;

    localparam int TX_FULL  = 3;
    localparam int TX_EMPTY = 2;
    localparam int RX_FULL  = 1;
    localparam int OVF      = 0;

endpackage

// File: rtl/port_controller_if.sv
// Core strobes, port pins and the byte-stream handshakes of the port controller.
interface port_controller_if;
    import port_controller_pkg::*;

    logic [2:0] port_id;
    logic       port_read;
    logic       port_write;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic [3:0] out0;
    logic [3:0] out1;
    logic [3:0] out2;
    logic [3:0] out3;
    logic [3:0] in4;
    logic [3:0] in5;
    logic       tx_valid;
    logic [3:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [3:0] rx_data;
    logic       rx_ready;

    modport master (
        output port_id, port_read, port_write, wdata, in4, in5, tx_ready, rx_valid, rx_data,
        input  rdata, out0, out1, out2, out3, tx_valid, tx_data, rx_ready
    );

    modport slave (
        input  port_id, port_read, port_write, wdata, in4, in5, tx_ready, rx_valid, rx_data,
        output rdata, out0, out1, out2, out3, tx_valid, tx_data, rx_ready
    );

endinterface

// File: rtl/port_controller_fifo.sv
// Synchronous FIFO with registered storage; a push into a full FIFO is accepted when a pop frees a slot in the same cycle.
module port_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [AW:0]                 count_q, count_d;
    logic                        do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/port_controller.sv
// Decodes core port strobes into output latches, synchronized inputs, status and a TX FIFO / RX hold stream channel.
module port_controller
    import port_controller_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic              clock,
    input logic              reset,
    port_controller_if.slave bus
);
    logic [3:0][3:0]             out_q;
    logic [SYNC_STAGES-1:0][3:0] sync4_q, sync5_q;
    logic [3:0]                  hold_q, hold_d;
    logic                        rx_full_q, rx_full_d;
    logic                        ovf_q, ovf_d;
    logic                        tx_full, tx_empty, tx_pop, tx_push, ovf_evt;
    logic                        rd_stream, rd_status, wr_stream, rx_cap;
    logic [3:0]                  status;

    assign rd_stream = bus.port_read  && (bus.port_id == PORT_STREAM);
    assign rd_status = bus.port_read  && (bus.port_id == PORT_STATUS);
    assign wr_stream = bus.port_write && (bus.port_id == PORT_STREAM);

    assign tx_pop  = !tx_empty && bus.tx_ready;
    assign tx_push = wr_stream;
    // A same-cycle pop makes room, so only a truly blocked push counts as overflow.
    assign ovf_evt = wr_stream && tx_full && !tx_pop;
    assign rx_cap  = bus.rx_valid && !rx_full_q;

    port_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_tx_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .data_i  (bus.wdata),
        .data_o  (bus.tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full_q;
    assign bus.out0     = out_q[0];
    assign bus.out1     = out_q[1];
    assign bus.out2     = out_q[2];
    assign bus.out3     = out_q[3];

    always_comb begin
        status           = '0;
        status[TX_FULL]  = tx_full;
        status[TX_EMPTY] = tx_empty;
        status[RX_FULL]  = rx_full_q;
        status[OVF]      = ovf_q;
    end

    // Capture wins over a same-cycle read so data arriving into an empty hold is not lost.
    always_comb begin
        hold_d    = hold_q;
        rx_full_d = rx_full_q;
        ovf_d     = ovf_q;
        if (rx_cap) begin
            hold_d    = bus.rx_data;
            rx_full_d = 1'b1;
        end else if (rd_stream) begin
            rx_full_d = 1'b0;
        end
        if (ovf_evt)        ovf_d = 1'b1;
        else if (rd_status) ovf_d = 1'b0;
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.port_id)
            PORT_OUT0, PORT_OUT1,
            PORT_OUT2, PORT_OUT3: bus.rdata = out_q[bus.port_id[1:0]];
            PORT_IN4:             bus.rdata = sync4_q[SYNC_STAGES-1];
            PORT_IN5:             bus.rdata = sync5_q[SYNC_STAGES-1];
            PORT_STATUS:          bus.rdata = status;
            PORT_STREAM:          bus.rdata = rx_full_q ? hold_q : 4'h0;
            default:              bus.rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            sync4_q   <= '0;
            sync5_q   <= '0;
            hold_q    <= '0;
            rx_full_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync4_q   <= {sync4_q[SYNC_STAGES-2:0], bus.in4};
            sync5_q   <= {sync5_q[SYNC_STAGES-2:0], bus.in5};
            if (bus.port_write && !bus.port_id[2]) out_q[bus.port_id[1:0]] <= bus.wdata;
            hold_q    <= hold_d;
            rx_full_q <= rx_full_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: doc/port_controller.md
# port_controller

I/O port controller for the command-controlled device. It decodes the device's `port_id` / `port_read` / `port_write` strobes into four output latches, two synchronized input ports, a status register and a buffered byte-stream channel (TX FIFO plus RX holding register with valid/ready handshakes). The core's `data_out` feeds the write path. The returned read data drives the core's `data_in`.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on input ports 4 and 5; ≥2.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `port_id`  in  3  port address from the core.
- `port_read`  in  1  core read strobe, one cycle per access.
- `port_write`  in  1  core write strobe, one cycle per access.
- `wdata`  in  4  core write data (core `data_out`).
- `rdata`  out  4  read data to core `data_in`; combinational.
- `out0`..`out3`  out  4 each  output port latches.
- `in4`, `in5`  in  4 each  asynchronous external inputs.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  4  TX FIFO head.
- `tx_ready`  in  1  consumer accepts head.
- `rx_valid`  in  1  producer offers `rx_data`.
- `rx_data`  in  4  incoming nibble.
- `rx_ready`  out  1  = ~rx_full.

## Operation
- **Address map:**
  - 0–3: output latches. Read returns the latch value.
  - 4–5: synchronized inputs. Writes are ignored.
  - 6: status {tx_full, tx_empty, rx_full, overflow}.
  - 7: write pushes the TX FIFO; read pops the RX holding register.
- **Port 0–3 write:** the latch takes `wdata` at the strobe edge.
- **Port 7 write, FIFO not full:** `wdata` is pushed.
- **Port 7 write, FIFO full:**
  - The data is dropped and the sticky `overflow` flag is set.
  - Exception: if `tx_valid & tx_ready` pops in the same cycle, the push succeeds, count is unchanged and `overflow` stays clear.
- **TX drain:** pop on `tx_valid & tx_ready`. Push into an empty FIFO: `tx_valid` rises the next cycle.
- **RX capture:** on `rx_valid & rx_ready`, `rx_data` goes into the hold register and `rx_full` is set.
- **Port 7 read:**
  - `rdata` = hold value if `rx_full`, else 0.
  - `rx_full` clears at the edge.
  - A core read in the same cycle as a capture (hold empty) returns 0, and the new data is held.
- **Port 6 read:** returns status, then clears `overflow` at the edge. If an overflow event happens in the same cycle, `overflow` stays set.
- **Simultaneous `port_read` and `port_write`:**
  - Both take effect.
  - `rdata` reflects pre-edge state.
  - Port 7 read and write are independent (RX pop, TX push).
- **Strobes with other ports:** reads of ports 0–5 have no side effects.

## Timing
- `rdata` is a combinational mux of registered sources, valid in the same cycle as `port_read`. The core samples it at that edge.
- Write latency is 1 cycle: a latch or FIFO entry is visible after the strobe edge.
- `in4`/`in5` changes appear on `rdata` `SYNC_STAGES` cycles later.
- **Reset values** (asynchronous, while `reset` = 0):
  - out0–3 = 0
  - TX FIFO empty: `tx_valid` = 0, `tx_data` = 0
  - `rx_full` = 0, so `rx_ready` = 1
  - `overflow` = 0
  - synchronizer flops = 0
- Reset mid-transfer discards FIFO contents and hold data, with no handshake completion.
- FIFO pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. The count is `log2(FIFO_DEPTH)+1` bits; full = (count == FIFO_DEPTH).

## Structure
- Shared package holds:
  - port address constants: PORT_OUT0..3 = 0..3, PORT_IN4 = 4, PORT_IN5 = 5, PORT_STATUS = 6, PORT_STREAM = 7
  - status bit positions: TX_FULL = 3, TX_EMPTY = 2, RX_FULL = 1, OVF = 0
- One sub-module, `port_fifo`: parameterized synchronous FIFO with push/pop/full/empty/head and simultaneous push+pop support.
- Synchronizers, RX hold register, status logic and the read mux stay in the top level.

## Test plan
- Reset, then write 0xA to port 2 → `out2` = 0xA next cycle; read port 2 → `rdata` = 0xA; out0/1/3 = 0.
- `in5` = 0x6 → port 5 reads 0 for cycles 0–1 and 0x6 from cycle 2 (`SYNC_STAGES` = 2).
- With `tx_ready` = 0, write 1,2,3,4,5 to port 7:
  - status read = 0b1001 (full, overflow)
  - the next status read = 0b1000
  - with `tx_ready` = 1, `tx_data` drains 1,2,3,4
- FIFO full and `tx_ready` = 1, write 0x9 in the same cycle → no overflow, count stays 4, 0x9 emerges last.
- `rx_valid` = 1, `rx_data` = 0xC → `rx_ready` drops.
  - Read port 7 → `rdata` = 0xC and `rx_ready` = 1 next cycle.
  - Read port 7 again → `rdata` = 0.
- Mid-drain, assert `reset` = 0 → `tx_valid`, outputs and status return to reset values immediately, without waiting for a clock edge.
